ram_if_arbiter: RTL and testbench
=================================

RAM_IF_ARBITER -- requirements
Module: ram_if_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: max consecutive grants to one port while the other port waits.
REQ-002 Parameter ADDR_SELECT_NONE, default 0: reserved; shall have no functional effect.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 resetb  input  1  asynchronous, active-low reset.
REQ-005 in_0  Ram_if.client  -  requester port 0 (en, addr, data_w, we, be in; data_r, delay out).
REQ-006 in_1  Ram_if.client  -  requester port 1, same signal set.
REQ-007 mem  Ram_if.memory  -  shared memory port (en, addr, data_w, we, be out; data_r, delay in).

Function
REQ-008 Timing convention: access presented with en=1 in cycle t; in_x.data_r and in_x.delay in t+1 refer to it; delay=1 in t+1 means not performed, requester shall re-present it unchanged.
REQ-009 Winner's addr, data_w, we, be, en forward combinationally to mem in the same cycle (zero added latency).
REQ-010 No en on either port: mem.en=0; mem.addr/data_w/be follow in_0; mem.we=0.
REQ-011 Loser of cycle t (en=1, not granted) gets delay=1 in t+1; its request is not forwarded.
REQ-012 Registered grant gnt_d and state: IDLE (no access issued last cycle), ACC0, ACC1 (access issued for port 0/1 last cycle).
REQ-013 Transitions each cycle: to ACC0/ACC1 per granted port; to IDLE if no grant.
REQ-014 In ACCx: in_x.data_r=mem.data_r, in_x.delay=mem.delay; the other port gets data_r=mem.data_r, delay=its lost flag.
REQ-015 In IDLE: both data_r=mem.data_r; delay = lost flag of that port (0 when none).
REQ-016 Lock: state ACCx and mem.delay=1 -> port x wins this cycle unconditionally; burst counter not incremented.
REQ-017 Burst counter (width clog2(MAX_BURST+1)): +1 per grant to the same port as the previous grant while the other port has en=1; reset to 1 on switch; 0 in IDLE.
REQ-018 Counter == MAX_BURST and other port requesting and not locked -> grant forced to other port.
REQ-019 Lone requester always granted (counter saturates at MAX_BURST, no forced switch).
REQ-020 Simultaneous requests, no lock, no burst limit: tie-break per REQ-025.
REQ-021 Stores (we=1) follow identical rules; a lost store is never written.

Reset
REQ-022 resetb low: state IDLE, gnt_d=0, last-grant pointer=1, burst counter=0, lost flags=0, immediately and asynchronously.
REQ-023 Outputs during reset: mem.en=0, mem.we=0, in_0.delay=in_1.delay=0.
REQ-024 Reset mid-access: pending access discarded; no retry issued by the arbiter after release.

Configuration
REQ-025 Macro RAM_IF_ARBITER_ROUND_ROBIN_EN: defined -> tie goes to the port not granted last (pointer updated on every grant); undefined -> tie goes to port 0; starvation bounded only by MAX_BURST.

Structure
REQ-026 Shared package ram_if_arbiter_pkg: state enum (IDLE, ACC0, ACC1), default MAX_BURST constant.
REQ-027 One sub-module, ram_if_arb_pick: combinational two-way grant selection (requests, lock, burst-limit, pointer in; grant out).

Verification
REQ-028 in_0 read addr 0x10 alone, mem.data_r=0xA5 next cycle -> mem.en=1 same cycle, in_0.data_r=0xA5, in_0.delay=0 in t+1.
REQ-029 Both ports en, cycle after reset, RR build -> port 0 granted, in_1.delay=1 in t+1; re-presented port 1 granted in t+1.
REQ-030 Both ports held en 10 cycles, fixed-priority build, MAX_BURST=4 -> grant pattern 0,0,0,0,1,0,0,0,0,1.
REQ-031 Port 1 store, mem.delay=1 for 2 cycles, port 0 requesting -> port 1 kept granted 3 cycles, exactly one completed write, then port 0 granted.
REQ-032 resetb low during ACC1 with mem.delay=1 -> state IDLE, all delay=0, mem.en=0 until a new request.
REQ-033 No requests 5 cycles -> mem.en=0, mem.we=0, both delay=0 every cycle.

Source files
------------

// File: rtl/ram_if_arbiter_pkg.sv
// ============================================================================
// Module  : ram_if_arbiter_pkg
// Brief   : Shared types and constants for the two-port RAM interface arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_if_arbiter_pkg;

    localparam int c_ADDR_W            = 16;
    localparam int c_DATA_W            = 32;
    localparam int c_BE_W              = c_DATA_W / 8;
    localparam int c_MAX_BURST_DEFAULT = 4;

    // Which port, if any, had an access issued in the previous cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/ram_if.sv
// ============================================================================
// Module  : Ram_if
// Brief   : Single-cycle RAM access interface; client side seen from the
//           arbiter, memory side driven by the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface Ram_if;

    logic                                           en;
    logic [ram_if_arbiter_pkg::c_ADDR_W-1:0]        addr;
    logic [ram_if_arbiter_pkg::c_DATA_W-1:0]        data_w;
    logic                                           we;
    logic [ram_if_arbiter_pkg::c_BE_W-1:0]          be;
    logic [ram_if_arbiter_pkg::c_DATA_W-1:0]        data_r;
    logic                                           delay;

    modport client (input en, addr, data_w, we, be, output data_r, delay);
    modport memory (output en, addr, data_w, we, be, input data_r, delay);

endinterface

`default_nettype wire

// File: rtl/ram_if_arb_pick.sv
// ============================================================================
// Module  : ram_if_arb_pick
// Brief   : Combinational two-way grant selection. Tie rule selected by
//           RAM_IF_ARBITER_ROUND_ROBIN_EN (defined: round robin, else port 0).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_if_arb_pick (
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic [1:0] limit,
    input  logic       ptr,
    output logic [1:0] grant
);

    logic w_tie_port;

`ifdef RAM_IF_ARBITER_ROUND_ROBIN_EN
    assign w_tie_port = ~ptr;
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ptr;
    assign w_tie_port   = 1'b0;
`endif

    // limit[x] means port x used up its burst and must yield to the other
    always_comb begin
        grant = 2'b00;
        if (lock[0] && req[0]) begin
            grant = 2'b01;
        end else if (lock[1] && req[1]) begin
            grant = 2'b10;
        end else if (req == 2'b11) begin
            if (limit[0])
                grant = 2'b10;
            else if (limit[1])
                grant = 2'b01;
            else
                grant = w_tie_port ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_if_arbiter.sv
// ============================================================================
// Module  : ram_if_arbiter
// Brief   : Zero-latency two-port arbiter onto one RAM port with stall lock and
//           burst limit. Option: RAM_IF_ARBITER_ROUND_ROBIN_EN (round-robin tie).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_if_arbiter
    import ram_if_arbiter_pkg::*;
#(
    parameter int MAX_BURST        = c_MAX_BURST_DEFAULT,
    parameter int ADDR_SELECT_NONE = 0
) (
    input  logic   clk,
    input  logic   resetb,
    Ram_if.client  in_0,
    Ram_if.client  in_1,
    Ram_if.memory  mem
);

    localparam int                 c_CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_BURST);
    localparam int                 c_unused_addr_select = ADDR_SELECT_NONE;

    arb_state_t         r_state;
    logic               r_gnt_d;
    logic               r_ptr;
    logic [c_CNT_W-1:0] r_burst;
    logic [1:0]         r_lost;

    logic [1:0] w_req;
    logic [1:0] w_lock;
    logic [1:0] w_limit;
    logic [1:0] w_grant;
    logic       w_same;
    logic       w_other_req;
    logic       w_locked;

    // Requests are masked while in reset so nothing reaches the memory
    assign w_req = {in_1.en, in_0.en} & {2{resetb}};

    assign w_lock[0]  = (r_state == ACC0) && mem.delay && w_req[0];
    assign w_lock[1]  = (r_state == ACC1) && mem.delay && w_req[1];
    assign w_limit[0] = (r_state == ACC0) && (r_burst == c_MAX) && w_req[1];
    assign w_limit[1] = (r_state == ACC1) && (r_burst == c_MAX) && w_req[0];

    ram_if_arb_pick u_pick (
        .req   (w_req),
        .lock  (w_lock),
        .limit (w_limit),
        .ptr   (r_ptr),
        .grant (w_grant)
    );

    assign w_same      = (r_state != IDLE) && (w_grant[1] == r_gnt_d);
    assign w_other_req = w_grant[1] ? w_req[0] : w_req[1];
    assign w_locked    = |w_lock;

    assign mem.en     = |w_grant;
    assign mem.addr   = w_grant[1] ? in_1.addr   : in_0.addr;
    assign mem.data_w = w_grant[1] ? in_1.data_w : in_0.data_w;
    assign mem.be     = w_grant[1] ? in_1.be     : in_0.be;
    assign mem.we     = (w_grant[1] & in_1.we) | (w_grant[0] & in_0.we);

    assign in_0.data_r = mem.data_r;
    assign in_1.data_r = mem.data_r;
    assign in_0.delay  = (r_state == ACC0) ? mem.delay : r_lost[0];
    assign in_1.delay  = (r_state == ACC1) ? mem.delay : r_lost[1];

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= IDLE;
            r_gnt_d <= 1'b0;
            r_ptr   <= 1'b1;
            r_burst <= '0;
            r_lost  <= 2'b00;
        end else begin
            r_lost <= w_req & ~w_grant;
            if (w_grant == 2'b00) begin
                r_state <= IDLE;
                r_burst <= '0;
            end else begin
                r_state <= w_grant[1] ? ACC1 : ACC0;
                r_gnt_d <= w_grant[1];
                r_ptr   <= w_grant[1];
                // A stalled retry is the same access, so it does not count
                if (!w_same)
                    r_burst <= c_CNT_W'(1);
                else if (!w_locked && w_other_req && (r_burst != c_MAX))
                    r_burst <= r_burst + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_if_arbiter.sv
// ============================================================================
// Module  : tb_ram_if_arbiter
// Brief   : Self-checking bench: vector table, corner sequences and random
//           traffic against a behavioural arbitration model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_if_arbiter;

    localparam int MAX_BURST = 4;

    logic clk;
    logic resetb;

    Ram_if p0 ();
    Ram_if p1 ();
    Ram_if m  ();

    ram_if_arbiter #(
        .MAX_BURST        (MAX_BURST),
        .ADDR_SELECT_NONE (0)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .in_0   (p0),
        .in_1   (p1),
        .mem    (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model state: port served last cycle (-1 none), length of the
    // current contested run, last port ever served, and who lost last cycle.
    int m_prev;
    int m_run;
    int m_ptr;
    bit m_lost [2];

    typedef struct {
        bit          e0;
        bit          we0;
        bit          e1;
        bit          we1;
        bit          md;
        logic [31:0] dr;
        int          gnt;
        bit          d0;
        bit          d1;
    } vec_t;

    vec_t tbl [9];
    int   exp_pat [10];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic int act_gnt();
        if (!m.en) return -1;
        return m.addr[15] ? 1 : 0;
    endfunction

    function automatic void reset_model();
        m_prev    = -1;
        m_run     = 0;
        m_ptr     = 1;
        m_lost[0] = 1'b0;
        m_lost[1] = 1'b0;
    endfunction

    task automatic clear_inputs();
        p0.en = 0; p0.we = 0; p0.addr = '0; p0.data_w = '0; p0.be = '0;
        p1.en = 0; p1.we = 0; p1.addr = 16'h8000; p1.data_w = '0; p1.be = '0;
        m.delay = 0; m.data_r = '0;
    endtask

    task automatic step(input bit e0, input bit we0, input bit e1, input bit we1,
                        input bit md, input logic [31:0] dr);
        int g;
        bit e [2];
        bit lk;
        @(negedge clk);
        p0.en = e0; p0.we = we0; p0.addr = {1'b0, 15'($urandom)};
        p0.data_w = $urandom; p0.be = 4'($urandom);
        p1.en = e1; p1.we = we1; p1.addr = {1'b1, 15'($urandom)};
        p1.data_w = $urandom; p1.be = 4'($urandom);
        m.delay = md; m.data_r = dr;
        #1;
        e[0] = e0;
        e[1] = e1;
        lk = (m_prev >= 0) && md && e[m_prev];
        if (lk)
            g = m_prev;
        else if (e0 && e1) begin
            if (m_prev >= 0 && m_run == MAX_BURST)
                g = 1 - m_prev;
            else
`ifdef RAM_IF_ARBITER_ROUND_ROBIN_EN
                g = 1 - m_ptr;
`else
                g = 0;
`endif
        end else if (e0)
            g = 0;
        else if (e1)
            g = 1;
        else
            g = -1;

        chk("mem_en",     m.en,     g >= 0);
        chk("mem_we",     m.we,     (g == 1) ? we1 : ((g == 0) ? we0 : 1'b0));
        chk("mem_addr",   m.addr,   (g == 1) ? p1.addr : p0.addr);
        chk("mem_data_w", m.data_w, (g == 1) ? p1.data_w : p0.data_w);
        chk("mem_be",     m.be,     (g == 1) ? p1.be : p0.be);
        chk("in0_delay",  p0.delay, (m_prev == 0) ? md : m_lost[0]);
        chk("in1_delay",  p1.delay, (m_prev == 1) ? md : m_lost[1]);
        chk("in0_data_r", p0.data_r, dr);
        chk("in1_data_r", p1.data_r, dr);

        if (g < 0) begin
            m_run = 0;
        end else begin
            if (m_prev != g)
                m_run = 1;
            else if (!lk && e[1-g] && m_run < MAX_BURST)
                m_run++;
            m_ptr = g;
        end
        m_prev    = g;
        m_lost[0] = e0 && (g != 0);
        m_lost[1] = e1 && (g != 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        resetb = 1'b0;
        #1;
        chk("rst_mem_en", m.en,     1'b0);
        chk("rst_in0_dl", p0.delay, 1'b0);
        chk("rst_in1_dl", p1.delay, 1'b0);
        @(negedge clk);
        resetb = 1'b1;
        reset_model();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int wr;
        int pg;
        vectors     = 0;
        miscompares = 0;
        resetb      = 1'b0;
        clear_inputs();
        reset_model();

        tbl[0] = '{1, 0, 0, 0, 0, 32'h0000_0000,  0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 0, 32'h0000_00A5, -1, 0, 0};
        tbl[2] = '{0, 0, 0, 0, 0, 32'h1234_5678, -1, 0, 0};
        tbl[3] = '{0, 0, 1, 1, 0, 32'h0000_0000,  1, 0, 0};
        tbl[4] = '{1, 0, 1, 1, 1, 32'hDEAD_BEEF,  1, 0, 1};
        tbl[5] = '{1, 0, 1, 0, 0, 32'h0000_0001,  0, 1, 0};
        tbl[6] = '{0, 0, 1, 0, 0, 32'h0000_0002,  1, 0, 1};
        tbl[7] = '{1, 1, 0, 0, 0, 32'h0000_0003,  0, 0, 0};
        tbl[8] = '{0, 0, 0, 0, 0, 32'h0000_0004, -1, 0, 0};

`ifdef RAM_IF_ARBITER_ROUND_ROBIN_EN
        exp_pat = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif

        // Requests asserted during reset must not reach the memory
        repeat (2) @(negedge clk);
        p0.en = 1; p0.we = 1; p1.en = 1; p1.we = 1; m.delay = 1;
        #1;
        chk("rst_mem_en", m.en,     1'b0);
        chk("rst_mem_we", m.we,     1'b0);
        chk("rst_in0_dl", p0.delay, 1'b0);
        chk("rst_in1_dl", p1.delay, 1'b0);
        @(negedge clk);
        clear_inputs();
        resetb = 1'b1;
        reset_model();

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].e0, tbl[i].we0, tbl[i].e1, tbl[i].we1, tbl[i].md, tbl[i].dr);
            chk("tbl_gnt",    act_gnt(),  tbl[i].gnt);
            chk("tbl_in0_dl", p0.delay,   tbl[i].d0);
            chk("tbl_in1_dl", p1.delay,   tbl[i].d1);
            chk("tbl_in0_dr", p0.data_r,  tbl[i].dr);
        end

        // Both ports held: burst limit / tie pattern
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 0, 0, 32'h0);
            chk("burst_gnt", act_gnt(), exp_pat[i]);
            if (i == 1) chk("tie_loser_dl", p1.delay, 1'b1);
        end

        // Stalled store from port 1 keeps the memory until it completes
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 1, 1, 0, 32'h0);
        chk("lock_gnt0", act_gnt(), 1);
        wr = 0;
        pg = act_gnt();
        step(1, 0, 1, 1, 1, 32'h0);
        chk("lock_gnt1", act_gnt(), 1);
        if (pg == 1 && p1.delay == 1'b0) wr++;
        pg = act_gnt();
        step(1, 0, 1, 1, 1, 32'h0);
        chk("lock_gnt2", act_gnt(), 1);
        if (pg == 1 && p1.delay == 1'b0) wr++;
        pg = act_gnt();
        step(1, 0, 0, 0, 0, 32'h0);
        chk("lock_release_gnt", act_gnt(), 0);
        chk("lock_waiter_dl",   p0.delay,  1'b1);
        if (pg == 1 && p1.delay == 1'b0) wr++;
        chk("store_writes", wr, 1);

        // Reset while port 1 is stalled
        step(0, 0, 1, 1, 0, 32'h0);
        @(negedge clk);
        m.delay = 1'b1;
        resetb  = 1'b0;
        #1;
        chk("rst_mid_en",   m.en,     1'b0);
        chk("rst_mid_we",   m.we,     1'b0);
        chk("rst_mid_in0",  p0.delay, 1'b0);
        chk("rst_mid_in1",  p1.delay, 1'b0);
        clear_inputs();
        @(negedge clk);
        resetb = 1'b1;
        reset_model();
        step(0, 0, 0, 0, 1, 32'h0);
        chk("post_rst_in1_dl", p1.delay, 1'b0);
        chk("post_rst_en",     m.en,     1'b0);

        // Idle stretch
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 32'h0);
            chk("idle_en",     m.en,     1'b0);
            chk("idle_in0_dl", p0.delay, 1'b0);
            chk("idle_in1_dl", p1.delay, 1'b0);
        end
        step(1, 0, 0, 0, 0, 32'h0);
        chk("new_req_gnt", act_gnt(), 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 3) != 0, 1'($urandom),
                 $urandom_range(0, 2) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
